// File: rtl/requant_tile_ctrl.sv
// Tile sequencer for the ReLU + saturating INT16->INT8 requantise stage: fill a tile buffer, then replay it.
// Optional rounding right-shift before the clip is enabled with `define RELU_REQ_SHIFT_EN.
module requant_tile_ctrl #(
    parameter int MAX_ROWS = 8,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W:0]   num_rows,
    input  logic             abort,
`ifdef RELU_REQ_SHIFT_EN
    input  logic [3:0]       shift,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W:0]   MAX_ROWS_W = (CNT_W+1)'(MAX_ROWS);
    localparam logic [CNT_W:0]   ONE_W      = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] PTR_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PTR_ZERO   = CNT_W'(0);

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   last_idx_r;
    logic [3:0]         shift_r;
    logic               done_r;
    logic [63:0]        row_buf_r [MAX_ROWS];
    logic [CNT_W:0]     eff_rows_s;
    logic [CNT_W:0]     eff_m1_s;
    logic [3:0]         shift_in_s;
    logic               wr_fire_s;
    logic               rd_fire_s;
    logic               wr_last_s;
    logic               rd_last_s;

    // Rounding is done at 17 bits so v + 2^(s-1) can never wrap.
    function automatic logic [7:0] requant_elem(input logic [15:0] v, input logic [3:0] sh);
        logic signed [16:0] rnd;
        logic signed [16:0] t;
        rnd = (sh == 4'd0) ? 17'sd0 : (17'sd1 <<< (sh - 4'd1));
        t   = ($signed({v[15], v}) + rnd) >>> sh;
        if (t <= 17'sd0) begin
            return 8'd0;
        end else if (t > 17'sd127) begin
            return 8'd127;
        end else begin
            return t[7:0];
        end
    endfunction

    function automatic logic [63:0] requant_row(input logic [127:0] d, input logic [3:0] sh);
        logic [63:0] r;
        r = 64'd0;
        for (int j = 0; j < 8; j++) begin
            r[j*8 +: 8] = requant_elem(d[j*16 +: 16], sh);
        end
        return r;
    endfunction

`ifdef RELU_REQ_SHIFT_EN
    assign shift_in_s = shift;
`else
    assign shift_in_s = 4'd0;
`endif

    assign eff_rows_s = ((num_rows == ONE_W - ONE_W) || (num_rows > MAX_ROWS_W)) ? MAX_ROWS_W : num_rows;
    assign eff_m1_s   = eff_rows_s - ONE_W;
    assign wr_fire_s  = (state_r == FILL) && in_valid;
    assign rd_fire_s  = (state_r == DRAIN) && out_ready;
    assign wr_last_s  = (wr_ptr_r == last_idx_r);
    assign rd_last_s  = (rd_ptr_r == last_idx_r);

    // Next-state decode; abort overrides everything.
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    next_state_s = start ? FILL : IDLE;
                FILL:    next_state_s = (wr_fire_s && wr_last_s) ? DRAIN : FILL;
                DRAIN:   next_state_s = (rd_fire_s && rd_last_s) ? IDLE : DRAIN;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // State, pointers, latched tile configuration and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            last_idx_r <= PTR_ZERO;
            shift_r    <= 4'd0;
            done_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            done_r  <= rd_fire_s && rd_last_s && !abort;
            if (abort) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else if ((state_r == IDLE) && start) begin
                last_idx_r <= eff_m1_s[CNT_W-1:0];
                shift_r    <= shift_in_s;
                wr_ptr_r   <= PTR_ZERO;
                rd_ptr_r   <= PTR_ZERO;
            end else if (wr_fire_s) begin
                wr_ptr_r <= wr_last_s ? PTR_ZERO : (wr_ptr_r + PTR_ONE);
                rd_ptr_r <= PTR_ZERO;
            end else if (rd_fire_s) begin
                rd_ptr_r <= rd_last_s ? PTR_ZERO : (rd_ptr_r + PTR_ONE);
            end else begin
                wr_ptr_r <= wr_ptr_r;
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Tile buffer holds already-requantised rows; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s && !abort) begin
            row_buf_r[wr_ptr_r] <= requant_row(in_data, shift_r);
        end
    end

    assign in_ready  = (state_r == FILL);
    assign out_valid = (state_r == DRAIN);
    assign out_data  = (state_r == DRAIN) ? row_buf_r[rd_ptr_r] : 64'd0;
    assign out_last  = (state_r == DRAIN) && rd_last_s;
    assign busy      = (state_r != IDLE);
    assign done      = done_r;

endmodule

// File: tb/tb_requant_tile_ctrl.sv
// Directed self-checking bench for requant_tile_ctrl; shift checks are built only with RELU_REQ_SHIFT_EN.
module tb_requant_tile_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [3:0]   num_rows = 4'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = 128'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  out_data;
    logic         out_last;
    logic         busy;
    logic         done;
`ifdef RELU_REQ_SHIFT_EN
    logic [3:0]   shift = 4'd0;
`endif
    int checks = 0;
    int errors = 0;
    int pat0 [8] = '{-5, 0, 1, 127, 128, 300, -32768, 32767};
    int pat2 [8] = '{254, 1000, 6, -9, 0, 0, 0, 0};

    requant_tile_ctrl #(.MAX_ROWS(8), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .abort(abort),
`ifdef RELU_REQ_SHIFT_EN
        .shift(shift),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_q(int v, int sh);
        int t;
        t = (sh == 0) ? v : ((v + (1 << (sh - 1))) >>> sh);
        if (t <= 0) return 0;
        if (t > 127) return 127;
        return t;
    endfunction

    function automatic int elem(int mode, int i, int j);
        if (mode == 0) return pat0[j];
        if (mode == 1) return i * 16 + j + 1;
        return pat2[j];
    endfunction

    function automatic logic [127:0] gen_row(int mode, int i);
        logic [127:0] r;
        for (int j = 0; j < 8; j++) r[j*16 +: 16] = 16'(elem(mode, i, j));
        return r;
    endfunction

    function automatic logic [63:0] exp_row(int mode, int i, int sh);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[j*8 +: 8] = 8'(exp_q(elem(mode, i, j), sh));
        return r;
    endfunction

    task automatic begin_tile(int n);
        start = 1'b1;
        num_rows = 4'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic fill(int n, int mode);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data = gen_row(mode, i);
            tick();
        end
        in_valid = 1'b0;
        in_data = 128'd0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, in_ready, out_valid, out_last, done} !== 5'b0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b data=%h, expected 0", {busy, in_ready, out_valid, out_last, done}, out_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int done_cnt = 0;
        begin_tile(8);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL fill_entry: in_ready=%b busy=%b, expected 1 1", in_ready, busy);
        end
        fill(8, 0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL first_out_latency: out_valid=%b, expected 1", out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data !== 64'h7F007F7F_7F010000 || out_last !== (i == 7)) begin
                errors++; $display("FAIL basic_row%0d: data=%h last=%b, expected 7f007f7f7f010000 %b", i, out_data, out_last, (i == 7));
            end
            tick();
            if (done) done_cnt++;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done: pulses=%0d busy=%b, expected 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_stall();
        int idx = 0;
        logic stalled = 1'b0;
        logic rdy;
        logic [63:0] prev_d = 64'd0;
        logic prev_l = 1'b0;
        begin_tile(8);
        fill(8, 1);
        for (int cyc = 0; cyc < 200 && idx < 8; cyc++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_row(1, idx, 0) || out_last !== (idx == 7)) begin
                errors++; $display("FAIL stall_row%0d: valid=%b data=%h last=%b, expected 1 %h %b", idx, out_valid, out_data, out_last, exp_row(1, idx, 0), (idx == 7));
            end
            if (stalled) begin
                checks++;
                if (out_data !== prev_d || out_last !== prev_l) begin
                    errors++; $display("FAIL stall_hold: data=%h last=%b, expected %h %b", out_data, out_last, prev_d, prev_l);
                end
            end
            rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            prev_d = out_data;
            prev_l = out_last;
            stalled = !rdy;
            tick();
            if (rdy) idx++;
        end
        out_ready = 1'b0;
        checks++;
        if (idx != 8 || done !== 1'b1) begin
            errors++; $display("FAIL stall_done: rows=%0d done=%b, expected 8 1", idx, done);
        end
    endtask

    task automatic test_num_rows();
        int caps [2] = '{0, 12};
        begin_tile(3);
        fill(3, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_data !== exp_row(1, i, 0) || out_last !== (i == 2)) begin
                errors++; $display("FAIL rows3_row%0d: data=%h last=%b, expected %h %b", i, out_data, out_last, exp_row(1, i, 0), (i == 2));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rows3_done: done=%b busy=%b, expected 1 0", done, busy);
        end
        for (int c = 0; c < 2; c++) begin
            int n = 0;
            int last_at = -1;
            begin_tile(caps[c]);
            fill(8, 1);
            for (int cyc = 0; cyc < 20 && !done; cyc++) begin
                if (out_valid) begin
                    if (out_last) last_at = n;
                    n++;
                end
                tick();
            end
            checks++;
            if (n != 8 || last_at != 7) begin
                errors++; $display("FAIL rows_cap%0d: rows=%0d last_at=%0d, expected 8 7", caps[c], n, last_at);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        begin_tile(8);
        fill(4, 1);
        in_valid = 1'b1;
        in_data = gen_row(1, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, busy, done, out_valid} !== 4'b0) begin
            errors++; $display("FAIL abort_idle: ready/busy/done/valid=%b, expected 0000", {in_ready, busy, done, out_valid});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: done=%b, expected 0", done);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL abort_beats_start: busy=%b, expected 0", busy);
        end
        begin_tile(8);
        fill(8, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data !== exp_row(1, i, 0) || out_last !== (i == 7)) begin
                errors++; $display("FAIL post_abort_row%0d: data=%h last=%b, expected %h %b", i, out_data, out_last, exp_row(1, i, 0), (i == 7));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL post_abort_done: done=%b, expected 1", done);
        end
    endtask

    task automatic test_drain_start_reset();
        int n = 0;
        int last_n = -1;
        begin_tile(8);
        fill(8, 1);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        start = 1'b1;
        num_rows = 4'd3;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== exp_row(1, 2, 0)) begin
            errors++; $display("FAIL drain_start_ignored: busy=%b valid=%b data=%h, expected 1 1 %h", busy, out_valid, out_data, exp_row(1, 2, 0));
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (out_valid) begin
                n++;
                if (out_last) last_n = n;
            end
            tick();
        end
        checks++;
        if (n != 6 || last_n != 6) begin
            errors++; $display("FAIL drain_remaining: rows=%0d last_at=%0d, expected 6 6", n, last_n);
        end
        begin_tile(8);
        fill(8, 1);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, in_ready, out_last} !== 4'b0 || out_data !== 64'd0) begin
            errors++; $display("FAIL async_reset: valid/busy/ready/last=%b data=%h, expected 0000 0", {out_valid, busy, in_ready, out_last}, out_data);
        end
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

`ifdef RELU_REQ_SHIFT_EN
    task automatic test_shift();
        shift = 4'd2;
        begin_tile(1);
        shift = 4'd0;
        fill(1, 2);
        checks++;
        if (out_data !== 64'h00000000_00027F40 || out_last !== 1'b1) begin
            errors++; $display("FAIL shift2: data=%h last=%b, expected 0000000000027f40 1", out_data, out_last);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_num_rows();
        test_abort();
        test_drain_start_reset();
`ifdef RELU_REQ_SHIFT_EN
        test_shift();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
